// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA line fetch path.
// Timing defaults, width defaults and the fetch FSM state encoding.
package vga_pkg;

  localparam int HD_DEF = 1280;
  localparam int VD_DEF = 1024;
  localparam int HR_DEF = 112;
  localparam int HB_DEF = 248;
  localparam int VR_DEF = 3;
  localparam int VB_DEF = 38;

  localparam int CNT_W_DEF  = 11;
  localparam int PIX_W_DEF  = 12;
  localparam int ADDR_W_DEF = 21;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } fetch_state_e;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vga_pix_fifo.sv
// Synchronous pixel FIFO with registered read data.
// Ports: clk, rst, flush, push/din, pop/dout, full, empty, count.
// dout holds the popped word for one cycle and is 0 after a non-pop.
module vga_pix_fifo
  import vga_pkg::*;
#(
  parameter int W     = PIX_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = occ_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && !flush
                && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      dout <= do_pop ? mem[rd_ptr] : '0;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count
               + CW'(do_push)
               - CW'(do_pop);
      end
    end
  end

endmodule

// File: rtl/vga_fetch_ctrl.sv
// Line-based pixel prefetch for a VGA scan-out pipe.
// In: clk, rst, hcount/vcount, pixel_enable, mem_ready, mem_rvalid,
// mem_rdata, err_clr. Out: mem_req/mem_addr, pix_rgb, underflow,
// late_line, busy.
module vga_fetch_ctrl
  import vga_pkg::*;
#(
  parameter int HD     = HD_DEF,
  parameter int VD     = VD_DEF,
  parameter int HR     = HR_DEF,
  parameter int HB     = HB_DEF,
  parameter int VR     = VR_DEF,
  parameter int VB     = VB_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  hcount,
  input  logic [CNT_W-1:0]  vcount,
  input  logic              pixel_enable,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  pix_rgb,
  output logic              underflow,
  output logic              late_line,
  input  logic              err_clr,
  output logic              busy
);

  localparam int CW = occ_w(DEPTH);

  // Horizontal sync/porch only shape the raster, not the fetch.
  localparam int unused_hblank = HR + HB;

  localparam logic [CNT_W-1:0] V_FIRST =
    CNT_W'(VR + VB);
  localparam logic [CNT_W-1:0] V_END =
    CNT_W'(VR + VB + VD);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(HD - 1);
  localparam logic [ADDR_W-1:0] HD_A =
    ADDR_W'(HD);
  localparam logic [CW:0] DEPTH_S =
    (CW + 1)'(DEPTH);

  fetch_state_e state;
  fetch_state_e state_nxt;

  logic [CNT_W-1:0]  issue;
  logic [ADDR_W-1:0] line_base;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     discard;
  logic              ignore;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  logic          line_start;
  logic          flush;
  logic          accept;
  logic          rsp;
  logic          rsp_drop;
  logic          rsp_push;
  logic          out_dec;
  logic          room;
  logic [CW-1:0] out_after;
  logic [CW-1:0] disc_after;
  logic [CW:0]   disc_sum;
  logic [CNT_W-1:0]  vrow;
  logic [ADDR_W-1:0] base_nxt;

  assign line_start = (hcount == '0)
                   && (vcount >= V_FIRST)
                   && (vcount < V_END);
  assign flush = (hcount == '0)
              && (vcount == '0);

  assign room = ({1'b0, fifo_count}
               + {1'b0, outstanding})
              < DEPTH_S;

  assign mem_req  = (state == FETCH)
                 && room && !fifo_full;
  assign mem_addr = line_base
                  + ADDR_W'(issue);
  assign accept   = mem_req && mem_ready;
  assign busy     = (state != IDLE);

  // After reset, stale responses are ignored until a line start.
  assign rsp      = mem_rvalid && !ignore;
  assign rsp_drop = rsp && (discard != '0);
  assign rsp_push = rsp && (discard == '0);
  assign out_dec  = rsp_push
                 && (outstanding != '0);

  assign out_after = outstanding
                   + CW'(accept)
                   - CW'(out_dec);
  assign disc_after = discard
                    - CW'(rsp_drop);
  assign disc_sum = {1'b0, disc_after}
                  + {1'b0, out_after};

  assign vrow     = vcount - V_FIRST;
  assign base_nxt = ADDR_W'(vrow) * HD_A;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (line_start) state_nxt = FETCH;
      end
      FETCH: begin
        if (line_start)
          state_nxt = FETCH;
        else if (accept && issue == LAST)
          state_nxt = WAIT;
      end
      WAIT: begin
        if (line_start)
          state_nxt = FETCH;
        else if (outstanding == '0)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      issue       <= '0;
      line_base   <= '0;
      outstanding <= '0;
      discard     <= '0;
      ignore      <= 1'b1;
      underflow   <= 1'b0;
      late_line   <= 1'b0;
    end else begin
      state <= state_nxt;

      if (line_start) begin
        issue     <= '0;
        line_base <= base_nxt;
        ignore    <= 1'b0;
      end else if (accept) begin
        issue <= issue + 1'b1;
      end

      // In-flight reads at a frame flush become discards.
      if (flush) begin
        outstanding <= '0;
        discard <= (disc_sum > DEPTH_S)
                 ? CW'(DEPTH)
                 : disc_sum[CW-1:0];
      end else begin
        outstanding <= out_after;
        discard     <= disc_after;
      end

      if (pixel_enable && fifo_empty)
        underflow <= 1'b1;
      else if (err_clr)
        underflow <= 1'b0;

      if (line_start && state == FETCH)
        late_line <= 1'b1;
      else if (err_clr)
        late_line <= 1'b0;
    end
  end

  vga_pix_fifo #(
    .W     (PIX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (rsp_push),
    .din   (mem_rdata),
    .pop   (pixel_enable),
    .dout  (pix_rgb),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_vga_fetch_ctrl.sv
// Bench for vga_fetch_ctrl: vector table plus line/frame sequences.
// Small raster: HD=8 VD=4 VR=1 VB=1 DEPTH=4.
module tb_vga_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        pixel_enable;
  logic        mem_req;
  logic [20:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [11:0] mem_rdata;
  logic [11:0] pix_rgb;
  logic        underflow;
  logic        late_line;
  logic        err_clr;
  logic        busy;

  vga_fetch_ctrl #(
    .HD(8), .VD(4), .HR(2), .HB(2),
    .VR(1), .VB(1), .CNT_W(11),
    .PIX_W(12), .ADDR_W(21), .DEPTH(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hcount       (hcount),
    .vcount       (vcount),
    .pixel_enable (pixel_enable),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .pix_rgb      (pix_rgb),
    .underflow    (underflow),
    .late_line    (late_line),
    .err_clr      (err_clr),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] data;
    int          due;
  } rsp_t;

  typedef struct {
    logic        rst;
    logic        pe;
    logic        clr;
    logic [10:0] hc;
    logic [10:0] vc;
    logic        uf;
    logic        busy;
    logic        req;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  rsp_t        rq[$];
  logic [11:0] q[$];
  int cyc      = 0;
  int lat      = 2;
  int exp_addr = 0;
  int n_acc    = 0;
  int inflight = 0;
  int max_inf  = 0;
  int pops     = 0;
  int drop_cnt = 0;
  bit model_ignore = 1'b1;
  bit auto_pop = 1'b0;
  bit pe_man   = 1'b0;

  vec_t tbl [13];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    logic        rv;
    logic [11:0] rd;
    logic        will_pop;
    logic [11:0] exp_pix;
    rsp_t        r;
    @(negedge clk);
    rv = 1'b0;
    rd = '0;
    if (rq.size() > 0 && rq[0].due == cyc + 1) begin
      r  = rq.pop_front();
      rv = 1'b1;
      rd = r.data;
      inflight--;
    end
    mem_rvalid = rv;
    mem_rdata  = rd;
    if (mem_req && mem_ready && !rst) begin
      chk("req_addr", 32'(mem_addr), 32'(exp_addr));
      r.data = 12'hAB4 + 12'(exp_addr);
      r.due  = cyc + 1 + lat;
      rq.push_back(r);
      exp_addr++;
      n_acc++;
      inflight++;
      if (inflight > max_inf) max_inf = inflight;
    end
    pixel_enable = auto_pop ? (q.size() > 0) : pe_man;
    will_pop = pixel_enable && q.size() > 0 && !rst;
    @(posedge clk);
    cyc++;
    #1;
    exp_pix = '0;
    if (rst) begin
      q.delete();
      drop_cnt = 0;
      model_ignore = 1'b1;
    end else begin
      if (will_pop) begin
        exp_pix = q.pop_front();
        pops++;
      end
      if (rv && !model_ignore) begin
        if (drop_cnt > 0) drop_cnt--;
        else q.push_back(rd);
      end
      if (hcount == 0 && vcount == 0) q.delete();
      if (hcount == 0 && vcount >= 2 && vcount < 6)
        model_ignore = 1'b0;
    end
    chk("pix_rgb", 32'(pix_rgb), 32'(exp_pix));
  endtask

  task automatic line_start(input int v);
    hcount = 11'd0;
    vcount = 11'(v);
    tick();
    hcount = 11'd1;
  endtask

  task automatic run_idle(input string nm);
    for (int i = 0; i < 300 &&
         (busy || q.size() > 0 || rq.size() > 0); i++)
      tick();
    chk(nm, 32'(busy), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 5, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 5, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 5, 0, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 5, 0, 1, 0, 0};
    tbl[4]  = '{0, 0, 1, 5, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 1, 5, 0, 1, 0, 0};
    tbl[6]  = '{0, 0, 1, 5, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 0, 5, 0, 1, 0, 0};
    tbl[8]  = '{1, 0, 0, 5, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 6, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 1, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 3, 2, 0, 0, 0};

    rst = 1'b1;
    hcount = 11'd5;
    vcount = 11'd0;
    pixel_enable = 1'b0;
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    err_clr = 1'b0;
    tick();
    tick();
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_late", 32'(late_line), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    foreach (tbl[i]) begin
      rst     = tbl[i].rst;
      pe_man  = tbl[i].pe;
      err_clr = tbl[i].clr;
      hcount  = tbl[i].hc;
      vcount  = tbl[i].vc;
      tick();
      chk($sformatf("vec%0d_uf", i),
          32'(underflow), 32'(tbl[i].uf));
      chk($sformatf("vec%0d_busy", i),
          32'(busy), 32'(tbl[i].busy));
      chk($sformatf("vec%0d_req", i),
          32'(mem_req), 32'(tbl[i].req));
    end
    rst = 1'b0;
    pe_man = 1'b0;
    err_clr = 1'b1;
    hcount = 11'd1;
    tick();
    err_clr = 1'b0;

    // Line at vcount=2: addresses 0..7, then WAIT, then IDLE.
    lat = 2; exp_addr = 0; n_acc = 0;
    max_inf = 0; pops = 0;
    mem_ready = 1'b1;
    auto_pop = 1'b1;
    line_start(2);
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_addr0", 32'(mem_addr), 32'd0);
    for (int i = 0; i < 100 && n_acc < 8; i++)
      tick();
    chk("s1_accepts", 32'(n_acc), 32'd8);
    chk("s1_wait", {30'd0, mem_req, busy}, 32'd1);
    run_idle("s1_idle");
    chk("s1_pops", 32'(pops), 32'd8);
    chk("s1_inflight_le4", 32'(max_inf <= 4), 32'd1);
    chk("s1_no_uf", 32'(underflow), 32'd0);

    // Line at vcount=3: base 8, first pixel 0xABC.
    exp_addr = 8; pops = 0;
    auto_pop = 1'b0;
    pe_man = 1'b0;
    line_start(3);
    chk("s2_req", 32'(mem_req), 32'd1);
    chk("s2_addr", 32'(mem_addr), 32'd8);
    for (int i = 0; i < 20 && q.size() == 0; i++)
      tick();
    pe_man = 1'b1;
    tick();
    pe_man = 1'b0;
    chk("s2_pix", 32'(pix_rgb), 32'hABC);
    tick();
    chk("s2_pix_zero", 32'(pix_rgb), 32'd0);
    auto_pop = 1'b1;
    run_idle("s2_idle");
    chk("s2_pops", 32'(pops), 32'd8);

    // Stalled memory for a whole line, then the next line starts.
    pops = 0;
    mem_ready = 1'b0;
    auto_pop = 1'b0;
    line_start(4);
    chk("s4_addr", 32'(mem_addr), 32'd16);
    repeat (12) tick();
    chk("s4_nolate", 32'(late_line), 32'd0);
    line_start(5);
    chk("s4_late", 32'(late_line), 32'd1);
    chk("s4_addr2", 32'(mem_addr), 32'd24);
    chk("s4_busy", 32'(busy), 32'd1);
    exp_addr = 24;
    err_clr = 1'b1;
    mem_ready = 1'b1;
    auto_pop = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("s4_clr", 32'(late_line), 32'd0);
    run_idle("s4_idle");
    chk("s4_pops", 32'(pops), 32'd8);

    // Frame flush with three reads in flight.
    lat = 10; exp_addr = 0;
    mem_ready = 1'b0;
    auto_pop = 1'b0;
    line_start(2);
    mem_ready = 1'b1;
    repeat (3) tick();
    mem_ready = 1'b0;
    chk("s5_addr", 32'(mem_addr), 32'd3);
    hcount = 11'd0;
    vcount = 11'd0;
    tick();
    hcount = 11'd1;
    drop_cnt = 3;
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_req", 32'(mem_req), 32'd0);
    for (int i = 0; i < 30 && rq.size() > 0; i++)
      tick();
    tick();
    pe_man = 1'b1;
    tick();
    pe_man = 1'b0;
    chk("s5_uf", 32'(underflow), 32'd1);
    chk("s5_pix", 32'(pix_rgb), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("s5_clr", 32'(underflow), 32'd0);
    lat = 2; exp_addr = 0; pops = 0;
    mem_ready = 1'b1;
    auto_pop = 1'b1;
    line_start(2);
    run_idle("s5_idle");
    chk("s5_pops", 32'(pops), 32'd8);

    // Reset in the middle of a fetch.
    lat = 3; exp_addr = 0;
    mem_ready = 1'b1;
    auto_pop = 1'b1;
    line_start(2);
    repeat (4) tick();
    mem_ready = 1'b0;
    auto_pop = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6_req", 32'(mem_req), 32'd0);
    chk("s6_addr", 32'(mem_addr), 32'd0);
    chk("s6_pix", 32'(pix_rgb), 32'd0);
    chk("s6_uf", 32'(underflow), 32'd0);
    chk("s6_late", 32'(late_line), 32'd0);
    chk("s6_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 20 && rq.size() > 0; i++)
      tick();
    tick();
    pe_man = 1'b1;
    tick();
    pe_man = 1'b0;
    chk("s6_stale_uf", 32'(underflow), 32'd1);
    chk("s6_stale_pix", 32'(pix_rgb), 32'd0);
    chk("s6_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
